rca_seq_adder: RTL

//  Multi-cycle parametrised adder/subtractor. It adds WIDTH-bit operands CHUNK bits per

---
 rtl/rca_pkg.sv | 11 +
 rtl/rca_chunk.sv | 28 ++
 rtl/rca_seq_adder.sv | 112 +++++++++++
 3 files changed

// File: rtl/rca_pkg.sv
// Shared types and helpers for the sequential ripple-carry adder.
package rca_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  // Chunk index width; at least one bit so the single-chunk case still has a counter.
  function automatic int unsigned idx_width(input int unsigned nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational ripple of CHUNK full-adder cells; c_msb is the carry into the top bit.
module rca_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/rca_seq_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit ripple slice reused WIDTH/CHUNK times,
// with the inter-chunk carry held in a register.
module rca_seq_adder
  import rca_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IW     = idx_width(NCHUNK);
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("rca_seq_adder: WIDTH must be a multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q, ovf_q;

  logic [CHUNK-1:0] chunk_x, chunk_y, chunk_s;
  logic             chunk_cout, chunk_c_msb;
  logic             accept, last;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid & in_ready & ~clr;
  assign last      = (state_q == BUSY) && (idx_q == LAST);

  assign chunk_x = a_q[int'(idx_q) * CHUNK +: CHUNK];
  assign chunk_y = b_q[int'(idx_q) * CHUNK +: CHUNK];

  rca_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .x    (chunk_x),
    .y    (chunk_y),
    .cin  (carry_q),
    .s    (chunk_s),
    .cout (chunk_cout),
    .c_msb(chunk_c_msb)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (idx_q == LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Result registers are left untouched by clr; only the handshake is aborted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (clr) begin
      idx_q <= '0;
    end else if (accept) begin
      idx_q   <= '0;
      a_q     <= a;
      b_q     <= b ^ {WIDTH{sub}};
      carry_q <= sub ? 1'b1 : cin;
    end else if (state_q == BUSY) begin
      sum_q[int'(idx_q) * CHUNK +: CHUNK] <= chunk_s;
      carry_q <= chunk_cout;
      idx_q   <= last ? '0 : idx_q + 1'b1;
      if (last) begin
        cout_q <= chunk_cout;
        ovf_q  <= chunk_cout ^ chunk_c_msb;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
